mm_batch_control: RTL and testbench

Parametrised top-level sequencer for the FIOS Montgomery multiplier. It runs a batch of up to `JOBS_MAX` multiplications against a single modulus held in BRAM. It loads p'0 and p once, then for each job loads operands a and b, starts the FIOS core, waits for completion, and writes the result to a per-job BRAM region. It sits between the BRAM port and the operand registers and FIOS core. It generalises the single-shot controller with:
- batch operation,
- non-overwriting result placement,
- a configurable BRAM read latency with pipeline drain,
- automatic return to idle.

---
 rtl/mm_ctrl_pkg.sv | 34 +++
 rtl/mm_en_delay.sv | 37 +++
 rtl/mm_batch_control.sv | 186 ++++++++++++++++++
 tb/tb_mm_batch_control.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_ctrl_pkg.sv
// Shared types and memory-map helpers for the batch Montgomery multiplier sequencer.
package mm_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_PP0,
        ST_LOAD_P,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_DRAIN,
        ST_FIOS_START,
        ST_FIOS_WAIT,
        ST_STORE_RES,
        ST_NEXT_JOB,
        ST_DONE
    } mm_state_t;

    // Fixed part of the BRAM memory map: p'0 first, then the s words of p.
    localparam int PP0_ADDR = 0;
    localparam int P_ADDR   = 1;

    // Bit positions of the operand-register load flags in the enable vector.
    localparam int EN_PP0 = 0;
    localparam int EN_P   = 1;
    localparam int EN_A   = 2;
    localparam int EN_B   = 3;
    localparam int EN_NUM = 4;

    // First address of job j's region (a, then b, then result, s words each).
    function automatic int job_base(input int j, input int s);
        return P_ADDR + s + 3 * s * j;
    endfunction

endpackage

// File: rtl/mm_en_delay.sv
// Delays the operand load flags by the BRAM read latency so each register
// enable lines up with the data word coming out of the BRAM.
module mm_en_delay
    import mm_ctrl_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int W      = EN_NUM
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic [W-1:0] en_i,
    output logic [W-1:0] en_o
);

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic [W-1:0] d_in;
        logic [W-1:0] q_reg;

        if (gi == 0) begin : g_head
            assign d_in = en_i;
        end else begin : g_tail
            assign d_in = g_stage[gi-1].q_reg;
        end

        // One pipeline stage; clear drops any enables still in flight.
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                q_reg <= '0;
            end else begin
                q_reg <= d_in;
            end
        end
    end

    assign en_o = g_stage[RD_LAT-1].q_reg;

endmodule

// File: rtl/mm_batch_control.sv
// Batch sequencer for the FIOS Montgomery multiplier: loads p'0 and p once,
// then per job loads a and b, runs the core and stores the result into the
// job's own BRAM region, returning to idle when the batch is finished.
module mm_batch_control
    import mm_ctrl_pkg::*;
#(
    parameter int s        = 8,
    parameter int JOBS_MAX = 4,
    parameter int RD_LAT   = 2,
    parameter int ADDR_W   = $clog2(1 + s + 3 * s * JOBS_MAX),
    parameter int JOB_W    = $clog2(JOBS_MAX + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [JOB_W-1:0]  job_count_i,
    input  logic              FIOS_done_i,
    output logic              p_prime_0_reg_en_o,
    output logic              p_reg_en_o,
    output logic              a_reg_en_o,
    output logic              b_reg_en_o,
    output logic              FIOS_start_o,
    output logic              BRAM_en_o,
    output logic              BRAM_we_o,
    output logic [ADDR_W-1:0] BRAM_addr_o,
    output logic [JOB_W-1:0]  job_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    // The word counter is shared by the s-word phases and the drain phase.
    localparam int CNT_MAX = (s > RD_LAT) ? s : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  WORD_LAST  = CNT_W'(s - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] PP0_A      = ADDR_W'(PP0_ADDR);
    localparam logic [ADDR_W-1:0] P_A        = ADDR_W'(P_ADDR);
    localparam logic [ADDR_W-1:0] B_OFF      = ADDR_W'(s);
    localparam logic [ADDR_W-1:0] RES_OFF    = ADDR_W'(2 * s);
    localparam logic [ADDR_W-1:0] JOB_STRIDE = ADDR_W'(3 * s);
    localparam logic [ADDR_W-1:0] BASE0      = ADDR_W'(job_base(0, s));
    localparam logic [JOB_W-1:0]  JOB_ONE    = JOB_W'(1);
    localparam logic [JOB_W-1:0]  JOBS_LIMIT = JOB_W'(JOBS_MAX);

    mm_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next;
    logic [JOB_W-1:0]  job_idx_reg, job_idx_next;
    logic [JOB_W-1:0]  job_cnt_reg, job_cnt_next;
    logic [ADDR_W-1:0] job_base_reg, job_base_next;
    logic              fios_start_reg;
    logic [EN_NUM-1:0] load_flags;
    logic [EN_NUM-1:0] load_flags_dly;
    logic [ADDR_W-1:0] word_off;
    logic              word_last;
    logic              drain_last;
    logic              counting;

    assign word_last  = (word_cnt_reg == WORD_LAST);
    assign drain_last = (word_cnt_reg == DRAIN_LAST);
    assign word_off   = ADDR_W'(word_cnt_reg);

    // Next-state logic plus latching of the batch parameters on start.
    always_comb begin
        state_next    = state_reg;
        job_idx_next  = job_idx_reg;
        job_cnt_next  = job_cnt_reg;
        job_base_next = job_base_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    job_cnt_next  = (job_count_i > JOBS_LIMIT) ? JOBS_LIMIT : job_count_i;
                    job_idx_next  = '0;
                    job_base_next = BASE0;
                    state_next    = (job_count_i == '0) ? ST_DONE : ST_LOAD_PP0;
                end
            end
            ST_LOAD_PP0:   state_next = ST_LOAD_P;
            ST_LOAD_P:     if (word_last) state_next = ST_LOAD_A;
            ST_LOAD_A:     if (word_last) state_next = ST_LOAD_B;
            ST_LOAD_B:     if (word_last) state_next = ST_DRAIN;
            ST_DRAIN:      if (drain_last) state_next = ST_FIOS_START;
            ST_FIOS_START: state_next = ST_FIOS_WAIT;
            ST_FIOS_WAIT:  if (FIOS_done_i) state_next = ST_STORE_RES;
            ST_STORE_RES:  if (word_last) state_next = ST_NEXT_JOB;
            ST_NEXT_JOB: begin
                if (job_idx_reg + JOB_ONE == job_cnt_reg) begin
                    state_next = ST_DONE;
                end else begin
                    job_idx_next  = job_idx_reg + JOB_ONE;
                    job_base_next = job_base_reg + JOB_STRIDE;
                    state_next    = ST_LOAD_A;
                end
            end
            ST_DONE:       state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Word counter advances only inside the multi-cycle phases and restarts on every state change.
    always_comb begin
        counting = (state_reg == ST_LOAD_P) || (state_reg == ST_LOAD_A) ||
                   (state_reg == ST_LOAD_B) || (state_reg == ST_DRAIN) ||
                   (state_reg == ST_STORE_RES);
        word_cnt_next = '0;
        if (counting && (state_next == state_reg)) begin
            word_cnt_next = word_cnt_reg + CNT_ONE;
        end
    end

    // BRAM port and undelayed load flags decoded from the current state.
    always_comb begin
        BRAM_addr_o = '0;
        BRAM_en_o   = 1'b0;
        BRAM_we_o   = 1'b0;
        load_flags  = '0;
        case (state_reg)
            ST_LOAD_PP0: begin
                BRAM_en_o          = 1'b1;
                BRAM_addr_o        = PP0_A;
                load_flags[EN_PP0] = 1'b1;
            end
            ST_LOAD_P: begin
                BRAM_en_o        = 1'b1;
                BRAM_addr_o      = P_A + word_off;
                load_flags[EN_P] = 1'b1;
            end
            ST_LOAD_A: begin
                BRAM_en_o        = 1'b1;
                BRAM_addr_o      = job_base_reg + word_off;
                load_flags[EN_A] = 1'b1;
            end
            ST_LOAD_B: begin
                BRAM_en_o        = 1'b1;
                BRAM_addr_o      = job_base_reg + B_OFF + word_off;
                load_flags[EN_B] = 1'b1;
            end
            ST_STORE_RES: begin
                BRAM_en_o   = 1'b1;
                BRAM_we_o   = 1'b1;
                BRAM_addr_o = job_base_reg + RES_OFF + word_off;
            end
            default: ;
        endcase
    end

    // State, counters and the registered core start pulse.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg      <= ST_IDLE;
            word_cnt_reg   <= '0;
            job_idx_reg    <= '0;
            job_cnt_reg    <= '0;
            job_base_reg   <= '0;
            fios_start_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_cnt_reg   <= word_cnt_next;
            job_idx_reg    <= job_idx_next;
            job_cnt_reg    <= job_cnt_next;
            job_base_reg   <= job_base_next;
            fios_start_reg <= (state_reg == ST_FIOS_START);
        end
    end

    mm_en_delay #(
        .RD_LAT (RD_LAT),
        .W      (EN_NUM)
    ) u_en_delay (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .en_i    (load_flags),
        .en_o    (load_flags_dly)
    );

    assign p_prime_0_reg_en_o = load_flags_dly[EN_PP0];
    assign p_reg_en_o         = load_flags_dly[EN_P];
    assign a_reg_en_o         = load_flags_dly[EN_A];
    assign b_reg_en_o         = load_flags_dly[EN_B];
    assign FIOS_start_o       = fios_start_reg;
    assign job_idx_o          = job_idx_reg;
    assign busy_o             = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done_o             = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mm_batch_control.sv
// Directed bench for mm_batch_control: three instances (RD_LAT 2, 1, 4) with
// s=4 and JOBS_MAX=4, each batch recorded cycle by cycle and compared with
// the memory map and timing worked out by hand.
module tb_mm_batch_control;

    localparam int S    = 4;
    localparam int JM   = 4;
    localparam int AW   = 6;
    localparam int JW   = 3;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start  [NDUT];
    logic          fdone  [NDUT];
    logic [JW-1:0] jcount [NDUT];
    logic          pp0_en [NDUT];
    logic          p_en   [NDUT];
    logic          a_en   [NDUT];
    logic          b_en   [NDUT];
    logic          fstart [NDUT];
    logic          ben    [NDUT];
    logic          bwe    [NDUT];
    logic [AW-1:0] addr   [NDUT];
    logic [JW-1:0] jidx   [NDUT];
    logic          busy   [NDUT];
    logic          done   [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        mm_batch_control #(
            .s        (S),
            .JOBS_MAX (JM),
            .RD_LAT   (gi == 0 ? 2 : (gi == 1 ? 1 : 4))
        ) u_dut (
            .clock_i            (clk),
            .reset_i            (rst),
            .start_i            (start[gi]),
            .job_count_i        (jcount[gi]),
            .FIOS_done_i        (fdone[gi]),
            .p_prime_0_reg_en_o (pp0_en[gi]),
            .p_reg_en_o         (p_en[gi]),
            .a_reg_en_o         (a_en[gi]),
            .b_reg_en_o         (b_en[gi]),
            .FIOS_start_o       (fstart[gi]),
            .BRAM_en_o          (ben[gi]),
            .BRAM_we_o          (bwe[gi]),
            .BRAM_addr_o        (addr[gi]),
            .job_idx_o          (jidx[gi]),
            .busy_o             (busy[gi]),
            .done_o             (done[gi])
        );
    end

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Recorded activity of the most recent batch.
    int rd_addr[$], rd_cyc[$], wr_addr[$], wr_job[$], wr_cyc[$];
    int pp0_cyc[$], p_cyc[$], a_cyc[$], b_cyc[$], fios_cyc[$], done_cyc[$];
    int busy_cnt, busy_at_done, addr_stray;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] outs_of(input int d);
        return {14'b0, pp0_en[d], p_en[d], a_en[d], b_en[d], fstart[d], ben[d], bwe[d],
                addr[d], jidx[d], busy[d], done[d]};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
        check_value({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check_value($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    // Run one batch on instance d; FIOS_done_i follows FIOS_start_o after wt cycles.
    // With poke set, start_i and FIOS_done_i are held high from job 0's LOAD_B to FIOS_START.
    task automatic run_batch(input int d, input int count, input int wt, input bit poke);
        int cyc, cd, stop_at, lat, n, dc, bs;
        bit poke_on, poke_done;
        int exp_rd[$], exp_cls[$], exp_wr[$], exp_wj[$], exp_rc[$];
        int exp_pp0[$], exp_p[$], exp_a[$], exp_b[$];
        rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_job.delete(); wr_cyc.delete();
        pp0_cyc.delete(); p_cyc.delete(); a_cyc.delete(); b_cyc.delete();
        fios_cyc.delete(); done_cyc.delete();
        busy_cnt = 0; busy_at_done = -1; addr_stray = 0;
        lat = lat_of(d);
        n = (count > JM) ? JM : count;

        @(negedge clk);
        jcount[d] = JW'(count);
        start[d]  = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        cyc = 1; cd = -1; stop_at = -1; poke_on = 1'b0; poke_done = 1'b0;
        while (cyc < 600 && (stop_at < 0 || cyc <= stop_at)) begin
            if (ben[d] && !bwe[d]) begin rd_addr.push_back(int'(addr[d])); rd_cyc.push_back(cyc); end
            if (ben[d] && bwe[d]) begin
                wr_addr.push_back(int'(addr[d])); wr_job.push_back(int'(jidx[d])); wr_cyc.push_back(cyc);
            end
            if (!ben[d] && (addr[d] != '0 || bwe[d])) addr_stray++;
            if (pp0_en[d]) pp0_cyc.push_back(cyc);
            if (p_en[d])   p_cyc.push_back(cyc);
            if (a_en[d])   a_cyc.push_back(cyc);
            if (b_en[d])   b_cyc.push_back(cyc);
            if (busy[d])   busy_cnt++;
            if (done[d]) begin
                done_cyc.push_back(cyc);
                busy_at_done = int'(busy[d]);
                if (stop_at < 0) stop_at = cyc + 3;
            end
            if (fstart[d]) begin fios_cyc.push_back(cyc); cd = wt; poke_on = 1'b0; end
            if (poke && !poke_done && ben[d] && !bwe[d] && addr[d] == AW'(1 + 2 * S)) begin
                poke_on = 1'b1; poke_done = 1'b1;
            end
            fdone[d] = poke_on || (cd == 0);
            start[d] = poke_on;
            if (cd >= 0) cd--;
            @(negedge clk);
            cyc++;
        end
        fdone[d] = 1'b0;
        start[d] = 1'b0;

        // Expected traffic from the memory map.
        if (n > 0) begin
            exp_rd.push_back(0); exp_cls.push_back(0);
            for (int k = 0; k < S; k++) begin exp_rd.push_back(1 + k); exp_cls.push_back(1); end
        end
        for (int j = 0; j < n; j++) begin
            bs = 1 + S + 3 * S * j;
            for (int k = 0; k < S; k++) begin exp_rd.push_back(bs + k); exp_cls.push_back(2); end
            for (int k = 0; k < S; k++) begin exp_rd.push_back(bs + S + k); exp_cls.push_back(3); end
            for (int k = 0; k < S; k++) begin exp_wr.push_back(bs + 2 * S + k); exp_wj.push_back(j); end
        end

        dc = qat(done_cyc, 0);
        check_value("done_pulses", done_cyc.size(), 1);
        check_value("busy_at_done", busy_at_done, 0);
        check_value("busy_cycles", busy_cnt, (dc > 0) ? dc - 1 : 0);
        check_value("addr_when_idle", addr_stray, 0);
        check_value("fios_pulses", fios_cyc.size(), n);
        cmp_q("rd_addr", rd_addr, exp_rd);
        cmp_q("wr_addr", wr_addr, exp_wr);
        cmp_q("wr_job", wr_job, exp_wj);
        if (n == 0) begin
            check_value("zero_done_cyc", dc, 1);
            check_value("zero_reg_en", pp0_cyc.size() + p_cyc.size() + a_cyc.size() + b_cyc.size(), 0);
        end else begin
            for (int i = 0; i < 1 + 3 * S; i++) exp_rc.push_back(i + 1);
            cmp_q("rd_cyc_job0", rd_cyc[0:3*S], exp_rc);
            check_value("fios_cyc0", qat(fios_cyc, 0), 3 * S + lat + 3);
            check_value("wait_honoured", qat(wr_cyc, 0), qat(fios_cyc, 0) + wt + 1);
            check_value("done_after_store", dc, qat(wr_cyc, wr_cyc.size() - 1) + 2);
            for (int i = 0; i < rd_cyc.size() && i < exp_cls.size(); i++) begin
                case (exp_cls[i])
                    0: exp_pp0.push_back(rd_cyc[i] + lat);
                    1: exp_p.push_back(rd_cyc[i] + lat);
                    2: exp_a.push_back(rd_cyc[i] + lat);
                    default: exp_b.push_back(rd_cyc[i] + lat);
                endcase
            end
            cmp_q("pp0_en_cyc", pp0_cyc, exp_pp0);
            cmp_q("p_en_cyc", p_cyc, exp_p);
            cmp_q("a_en_cyc", a_cyc, exp_a);
            cmp_q("b_en_cyc", b_cyc, exp_b);
            for (int j = 0; j < n; j++)
                check_value($sformatf("fios_after_b_%0d", j),
                            32'(qat(fios_cyc, j) > qat(b_cyc, (j + 1) * S - 1)), 1);
        end
        $display("batch dut=%0d count=%0d wait=%0d poke=%0d reads=%0d writes=%0d done_cyc=%0d",
                 d, count, wt, poke, rd_addr.size(), wr_addr.size(), dc);
    endtask

    // Start a 2-job batch on instance d and reset it mid-flight:
    // mode 0 in FIOS_WAIT, mode 1 on the second word of a (enables still in the pipeline).
    task automatic reset_mid(input int d, input int mode);
        int cyc;
        bit hit;
        logic stray;
        @(negedge clk);
        jcount[d] = JW'(2);
        start[d]  = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        hit = 1'b0; cyc = 0;
        while (!hit && cyc < 300) begin
            if (mode == 0 && fstart[d]) hit = 1'b1;
            if (mode == 1 && ben[d] && !bwe[d] && addr[d] == AW'(2 + S)) hit = 1'b1;
            if (!hit) begin @(negedge clk); cyc++; end
        end
        check_value($sformatf("rst_trigger_m%0d", mode), 32'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value($sformatf("rst_outs_m%0d", mode), outs_of(d), 0);
        stray = 1'b0;
        repeat (lat_of(d) + 2) begin
            @(negedge clk);
            stray = stray | pp0_en[d] | p_en[d] | a_en[d] | b_en[d] | fstart[d] | ben[d] | busy[d];
        end
        check_value($sformatf("rst_no_stray_m%0d", mode), 32'(stray), 0);
        $display("reset dut=%0d mode=%0d after %0d cycles", d, mode, cyc);
    endtask

    initial begin
        int p_reads;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            start[d] = 1'b0; fdone[d] = 1'b0; jcount[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++)
            check_value($sformatf("reset_outs_%0d", d), outs_of(d), 0);
        rst = 1'b0;

        // Single job.
        run_batch(0, 1, 3, 1'b0);

        // Three jobs: p once, job regions placed without overlap.
        run_batch(0, 3, 2, 1'b0);
        p_reads = 0;
        foreach (rd_addr[i]) if (rd_addr[i] >= 1 && rd_addr[i] <= S) p_reads++;
        check_value("p_read_once", p_reads, S);
        check_value("job1_a_first", qat(rd_addr, 13), 17);
        check_value("job1_res_first", qat(wr_addr, 4), 25);
        check_value("job2_res_first", qat(wr_addr, 8), 37);

        // Zero and oversized counts.
        run_batch(0, 0, 0, 1'b0);
        run_batch(0, 7, 1, 1'b0);
        check_value("clamp_last_write", qat(wr_addr, 15), 52);

        // Enable alignment with the other read latencies.
        run_batch(1, 2, 0, 1'b0);
        run_batch(2, 2, 4, 1'b0);

        // Reset mid-batch, then a clean rerun starting from address 0.
        reset_mid(0, 0);
        run_batch(0, 1, 2, 1'b0);
        reset_mid(2, 1);
        run_batch(2, 1, 1, 1'b0);

        // start_i and FIOS_done_i outside their states are ignored.
        run_batch(0, 2, 4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
